dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of 2, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted between request acceptance and response (0..15).
REQ-003 SHALL have ports clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid_i  input  1  initiator presents a request.
REQ-006 SHALL have req_ready_o  output  1  responder can accept a request.
REQ-007 SHALL have req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_addr_i  input  32  byte address.
REQ-009 SHALL have req_wdata_i  input  32  store data.
REQ-010 SHALL have req_be_i  input  4  store byte enables; bit n enables byte lane n (bits 8n+7:8n).
REQ-011 SHALL have rsp_valid_o  output  1  response present.
REQ-012 SHALL have rsp_ready_i  input  1  initiator accepts response.
REQ-013 SHALL have rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have rsp_err_o  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE; rsp_valid_o = 1 only in RESP.
REQ-016 Request SHALL be accepted on a rising edge where req_valid_i & req_ready_o; at most one request outstanding.
REQ-017 On acceptance SHALL latch we, error flag and read data; IDLE -> WAIT with wait counter = LATENCY, or IDLE -> RESP if LATENCY = 0.
REQ-018 In WAIT SHALL decrement the counter each cycle; at counter 1 SHALL go to RESP next edge, so rsp_valid_o rises exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 In RESP SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable until a rising edge with rsp_ready_i = 1, then go to IDLE; no request is accepted in that same edge.
REQ-020 Word index SHALL be req_addr_i[log2(DEPTH_WORDS)+1:2].
REQ-021 Error SHALL be set when req_addr_i[1:0] != 0 or req_addr_i >= 4*DEPTH_WORDS.
REQ-022 Error requests SHALL NOT modify storage and SHALL return rsp_rdata_o = 0, rsp_err_o = 1.
REQ-023 Valid store SHALL commit on the acceptance edge, writing only lanes with req_be_i bit set; req_be_i = 0 is a legal no-op store with rsp_err_o = 0.
REQ-024 Valid load SHALL return the full word as stored before the acceptance edge; req_be_i ignored for loads.
REQ-025 Request inputs SHALL be ignored while req_ready_o = 0; rsp_ready_i SHALL be ignored outside RESP.

Reset
REQ-026 While rst_i = 0: state IDLE, counter 0, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, independent of clk_i.
REQ-027 Storage contents SHALL be unaffected by reset; contents before the first store are undefined.
REQ-028 Reset asserted in WAIT or RESP SHALL discard the pending response; a store already committed at acceptance SHALL remain in storage.

Verification
REQ-029 Store addr 0x10, wdata 0xDEADBEEF, be 0xF, LATENCY 2 -> rsp_valid_o rises 3 cycles after acceptance, rsp_err_o 0, rsp_rdata_o 0; then load 0x10 -> rsp_rdata_o 0xDEADBEEF.
REQ-030 Store 0x10, wdata 0x11223344, be 0x5, over 0xDEADBEEF -> load 0x10 returns 0xDE22BE44.
REQ-031 Load addr 0x13 and load addr 0x400 (DEPTH_WORDS 256) -> rsp_err_o 1, rsp_rdata_o 0; storage at 0x10 unchanged.
REQ-032 Hold rsp_ready_i = 0 for 5 cycles in RESP with req_valid_i = 1 -> rsp_valid_o and data stable, req_ready_o 0, no second acceptance; rsp_ready_i = 1 -> IDLE next edge.
REQ-033 LATENCY 0 back-to-back loads with rsp_ready_i tied 1 -> one acceptance every 2 cycles, each response 1 cycle after its acceptance.
REQ-034 Assert rst_i = 0 mid-WAIT after store 0x20 = 0xCAFEF00D -> outputs reset immediately, no response; after release load 0x20 -> 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request and
// response handshake, with a fixed programmable response latency.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [DW-1:0]   mem_q [DEPTH_WORDS];

    logic            accept_c;
    logic            addr_err_c;
    logic            mem_we_c;
    logic [AW-1:0]   idx_c;
    logic [DW-1:0]   mem_rd_c;

    // Request decode: word index, address error and acceptance qualifier
    always_comb begin
        idx_c      = req_addr_i[AW+1:2];
        addr_err_c = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ADDR_LIMIT);
        accept_c   = req_valid_i && (state_q == ST_IDLE);
        mem_we_c   = accept_c && req_we_i && !addr_err_c;
        mem_rd_c   = mem_q[idx_c];
    end

    // Storage array: not reset, lanes written only on an accepted valid store
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (req_be_i[b]) begin
                    mem_q[idx_c][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // State, wait counter and latched response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE with latency countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response capture: read data is sampled before the same-edge store lands
    always_comb begin
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (accept_c) begin
            we_d    = req_we_i;
            err_d   = addr_err_c;
            rdata_d = (req_we_i || addr_err_c) ? '0 : mem_rd_c;
        end
    end

    // Output decode straight from registered state and response fields
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        if (state_q == ST_IDLE) begin
            req_ready_o = 1'b1;
        end
        if (state_q == ST_RESP) begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            rsp_rdata_o = (we_q || err_q) ? '0 : rdata_q;
        end
    end

endmodule
